// File: rtl/ghost_pkg.sv
// Shared types for the ghost direction scheduler: one-hot direction codes,
// mode encodings, FSM states and the direction reversal helper.
package ghost_pkg;

    localparam logic [3:0] DIR_STOP  = 4'b0000;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    typedef enum logic [1:0] {
        MODE_CHASE   = 2'd0,
        MODE_SCATTER = 2'd1,
        MODE_FRIGHT  = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DECIDE,
        DONE
    } state_e;

    // The encoding is laid out so that reversal is a plain bit-order swap.
    function automatic logic [3:0] reverse(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_CHASE : mode_e'(m);
    endfunction

endpackage

// File: rtl/ghost_dir_select.sv
// Combinational direction picker for one ghost; shared across ghosts by index.
// GHOST_FRIGHT_EN enables the LFSR-driven random pick in FRIGHT mode.
module ghost_dir_select
    import ghost_pkg::*;
#(
    parameter int X_W = 11,
    parameter int Y_W = 10
) (
    input  logic [X_W-1:0] i_pos_x,
    input  logic [Y_W-1:0] i_pos_y,
    input  logic [X_W-1:0] i_tgt_x,
    input  logic [Y_W-1:0] i_tgt_y,
    input  logic [3:0]     i_vm_moves,
    input  logic [3:0]     i_prev,
    input  logic           i_rev_pending,
    input  logic [1:0]     i_mode,
    input  logic [1:0]     i_lfsr,
    output logic [3:0]     o_dir
);

    localparam int D_W = ((X_W > Y_W) ? X_W : Y_W) + 1;

    logic signed [X_W:0] w_dx;
    logic signed [Y_W:0] w_dy;
    logic [X_W:0]        w_adx;
    logic [Y_W:0]        w_ady;
    logic                w_horiz;
    logic [3:0]          w_hstep, w_vstep, w_pri, w_sec;
    logic [3:0]          w_rev, w_cand;
    logic                w_rev_ok;

    assign w_dx  = $signed({1'b0, i_tgt_x}) - $signed({1'b0, i_pos_x});
    assign w_dy  = $signed({1'b0, i_tgt_y}) - $signed({1'b0, i_pos_y});
    assign w_adx = w_dx[X_W] ? -w_dx : w_dx;
    assign w_ady = w_dy[Y_W] ? -w_dy : w_dy;

    // Strictly greater keeps ties on the vertical axis.
    assign w_horiz = (D_W'(w_adx) > D_W'(w_ady));
    assign w_hstep = (w_dx == '0) ? DIR_STOP : (w_dx[X_W] ? DIR_LEFT : DIR_RIGHT);
    assign w_vstep = (w_dy == '0) ? DIR_STOP : (w_dy[Y_W] ? DIR_UP : DIR_DOWN);
    assign w_pri   = w_horiz ? w_hstep : w_vstep;
    assign w_sec   = w_horiz ? w_vstep : w_hstep;

    assign w_rev    = reverse(i_prev);
    assign w_cand   = i_vm_moves & ~w_rev;
    assign w_rev_ok = |(i_vm_moves & w_rev);

`ifdef GHOST_FRIGHT_EN
    logic [3:0] w_fright;
    logic [1:0] w_bit;
    logic       w_found;

    always_comb begin
        w_fright = DIR_STOP;
        w_found  = 1'b0;
        w_bit    = i_lfsr;
        for (int k = 0; k < 4; k++) begin
            w_bit = i_lfsr + 2'(k);
            if (!w_found && w_cand[w_bit]) begin
                w_fright = 4'b0001 << w_bit;
                w_found  = 1'b1;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_mode, i_lfsr};
`endif

    always_comb begin
        o_dir = DIR_STOP;
        if (i_rev_pending && w_rev_ok)
            o_dir = w_rev;
        else if (w_cand == 4'b0000)
            o_dir = w_rev_ok ? w_rev : DIR_STOP;
`ifdef GHOST_FRIGHT_EN
        else if (i_mode == MODE_FRIGHT)
            o_dir = w_fright;
`endif
        else if (|(w_pri & w_cand))
            o_dir = w_pri;
        else if (|(w_sec & w_cand))
            o_dir = w_sec;
        else if (w_cand[1])
            o_dir = DIR_UP;
        else if (w_cand[2])
            o_dir = DIR_DOWN;
        else if (w_cand[0])
            o_dir = DIR_RIGHT;
        else
            o_dir = DIR_LEFT;
    end

endmodule

// File: rtl/ghost_ai_scheduler.sv
// Time-multiplexed ghost steering: per move tick, scans all ghosts through the
// shared valid-move lookup and registers a one-hot direction for each.
// Optional macro GHOST_FRIGHT_EN builds the FRIGHT-mode LFSR.
module ghost_ai_scheduler
    import ghost_pkg::*;
#(
    parameter int                        NUM_GHOSTS = 4,
    parameter int                        X_W        = 11,
    parameter int                        Y_W        = 10,
    parameter logic [NUM_GHOSTS*X_W-1:0] SCATTER_X  = '0,
    parameter logic [NUM_GHOSTS*Y_W-1:0] SCATTER_Y  = '0,
    parameter logic [15:0]               LFSR_SEED  = 16'hACE1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_move_tick,
    input  logic [1:0]                  i_mode,
    input  logic [NUM_GHOSTS*X_W-1:0]   i_ghost_pos_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]   i_ghost_pos_y,
    input  logic [X_W-1:0]              i_pacman_pos_x,
    input  logic [Y_W-1:0]              i_pacman_pos_y,
    output logic                        o_vm_req,
    output logic [X_W-1:0]              o_vm_pos_x,
    output logic [Y_W-1:0]              o_vm_pos_y,
    input  logic                        i_vm_ack,
    input  logic [3:0]                  i_vm_moves,
    output logic [NUM_GHOSTS*4-1:0]     o_move_dir,
    output logic                        o_dir_valid,
    output logic                        o_busy,
    output logic                        o_tick_overrun
);

    localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);
    localparam logic [NUM_GHOSTS-1:0][X_W-1:0] SCAT_X = SCATTER_X;
    localparam logic [NUM_GHOSTS-1:0][Y_W-1:0] SCAT_Y = SCATTER_Y;

    state_e                         r_state, w_next;
    logic [IDX_W-1:0]               r_idx;
    logic [NUM_GHOSTS-1:0][X_W-1:0] r_snap_x;
    logic [NUM_GHOSTS-1:0][Y_W-1:0] r_snap_y;
    logic [X_W-1:0]                 r_pac_x;
    logic [Y_W-1:0]                 r_pac_y;
    mode_e                          r_mode, r_mode_q;
    logic [NUM_GHOSTS-1:0]          r_rev_pending;
    logic [3:0]                     r_moves;
    logic [NUM_GHOSTS-1:0][3:0]     r_dir;
    logic                           r_overrun;

    mode_e                          w_mode_in;
    logic [X_W-1:0]                 w_tgt_x;
    logic [Y_W-1:0]                 w_tgt_y;
    logic [3:0]                     w_sel;
    logic [1:0]                     w_lfsr;

    assign w_mode_in = norm_mode(i_mode);

`ifdef GHOST_FRIGHT_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_lfsr = r_lfsr[1:0];
`else
    logic [15:0] w_unused_seed;
    assign w_unused_seed = LFSR_SEED;
    assign w_lfsr        = 2'b00;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_vm_req    = 1'b0;
        o_busy      = 1'b1;
        o_dir_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_move_tick)
                    w_next = REQ;
            end
            REQ: begin
                o_vm_req = 1'b1;
                if (i_vm_ack)
                    w_next = DECIDE;
            end
            DECIDE:
                w_next = (r_idx == LAST_IDX) ? DONE : REQ;
            DONE: begin
                o_dir_valid = 1'b1;
                w_next      = IDLE;
            end
            default:
                w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx         <= '0;
            r_snap_x      <= '0;
            r_snap_y      <= '0;
            r_pac_x       <= '0;
            r_pac_y       <= '0;
            r_mode        <= MODE_CHASE;
            r_mode_q      <= MODE_CHASE;
            r_rev_pending <= '0;
            r_moves       <= '0;
            r_dir         <= {NUM_GHOSTS{DIR_LEFT}};
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= i_move_tick && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (i_move_tick) begin
                        r_snap_x <= i_ghost_pos_x;
                        r_snap_y <= i_ghost_pos_y;
                        r_pac_x  <= i_pacman_pos_x;
                        r_pac_y  <= i_pacman_pos_y;
                        r_mode   <= w_mode_in;
                        r_idx    <= '0;
                        // A mode switch makes every ghost turn around once.
                        if (w_mode_in != r_mode_q) begin
                            r_rev_pending <= '1;
                            r_mode_q      <= w_mode_in;
                        end
                    end
                end
                REQ: begin
                    if (i_vm_ack)
                        r_moves <= i_vm_moves;
                end
                DECIDE: begin
                    r_dir[r_idx]         <= w_sel;
                    r_rev_pending[r_idx] <= 1'b0;
                    if (r_idx != LAST_IDX)
                        r_idx <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // FRIGHT borrows the scatter target; it only matters when the random pick is off.
    assign w_tgt_x = (r_mode == MODE_CHASE) ? r_pac_x : SCAT_X[r_idx];
    assign w_tgt_y = (r_mode == MODE_CHASE) ? r_pac_y : SCAT_Y[r_idx];

    ghost_dir_select #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_sel (
        .i_pos_x       (r_snap_x[r_idx]),
        .i_pos_y       (r_snap_y[r_idx]),
        .i_tgt_x       (w_tgt_x),
        .i_tgt_y       (w_tgt_y),
        .i_vm_moves    (r_moves),
        .i_prev        (r_dir[r_idx]),
        .i_rev_pending (r_rev_pending[r_idx]),
        .i_mode        (r_mode),
        .i_lfsr        (w_lfsr),
        .o_dir         (w_sel)
    );

    assign o_vm_pos_x     = r_snap_x[r_idx];
    assign o_vm_pos_y     = r_snap_y[r_idx];
    assign o_move_dir     = r_dir;
    assign o_tick_overrun = r_overrun;

endmodule

// File: tb/tb_ghost_ai_scheduler.sv
// Directed + randomized bench for ghost_ai_scheduler with a behavioural
// steering model; default build (GHOST_FRIGHT_EN undefined).
module tb_ghost_ai_scheduler;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [N-1:0][10:0] gx;
    logic [N-1:0][9:0]  gy;
    logic [10:0]        px;
    logic [9:0]         py;
    logic               ack = 1'b0;
    logic [3:0]         moves = 4'd0;
    logic               o_vm_req, o_dir_valid, o_busy, o_tick_overrun;
    logic [10:0]        o_vm_pos_x;
    logic [9:0]         o_vm_pos_y;
    logic [N*4-1:0]     o_move_dir;

    ghost_ai_scheduler #(
        .NUM_GHOSTS (N),
        .X_W        (11),
        .Y_W        (10),
        .SCATTER_X  ({11'd1000, 11'd0, 11'd1000, 11'd0}),
        .SCATTER_Y  ({10'd700, 10'd700, 10'd0, 10'd0}),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_move_tick    (tick),
        .i_mode         (mode),
        .i_ghost_pos_x  (gx),
        .i_ghost_pos_y  (gy),
        .i_pacman_pos_x (px),
        .i_pacman_pos_y (py),
        .o_vm_req       (o_vm_req),
        .o_vm_pos_x     (o_vm_pos_x),
        .o_vm_pos_y     (o_vm_pos_y),
        .i_vm_ack       (ack),
        .i_vm_moves     (moves),
        .o_move_dir     (o_move_dir),
        .o_dir_valid    (o_dir_valid),
        .o_busy         (o_busy),
        .o_tick_overrun (o_tick_overrun)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_pass = 0, n_fail = 0;
    int         cyc = 0, ov = 0;
    bit         xtick = 1'b0;
    logic [3:0] mdir[N];
    bit         revp[N];
    int         mq = 0;
    int         scx[N] = '{0, 1000, 0, 1000};
    int         scy[N] = '{0, 0, 700, 700};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steering rules computed directly with signed integers.
    function automatic logic [3:0] m_sel(input int gxp, gyp, tx, ty,
                                         input logic [3:0] mv, prev, input bit rp);
        logic [3:0] rv, cand, h, v, p, s;
        int dx, dy, ax, ay;
        case (prev)
            4'b0001: rv = 4'b1000;
            4'b1000: rv = 4'b0001;
            4'b0010: rv = 4'b0100;
            4'b0100: rv = 4'b0010;
            default: rv = 4'b0000;
        endcase
        if (rp && ((mv & rv) != 0)) return rv;
        cand = mv & ~rv;
        if (cand == 0) return ((mv & rv) != 0) ? rv : 4'b0000;
        dx = tx - gxp;
        dy = ty - gyp;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        h  = (dx > 0) ? 4'b0001 : ((dx < 0) ? 4'b1000 : 4'b0000);
        v  = (dy > 0) ? 4'b0100 : ((dy < 0) ? 4'b0010 : 4'b0000);
        if (ax > ay) begin p = h; s = v; end
        else begin p = v; s = h; end
        if ((p & cand) != 0) return p;
        if ((s & cand) != 0) return s;
        if (cand[1]) return 4'b0010;
        if (cand[2]) return 4'b0100;
        if (cand[0]) return 4'b0001;
        return 4'b1000;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        tick = xtick && (cyc == 2);
        if (o_tick_overrun) ov++;
    endtask

    task automatic set_pos(input int x, input int y, input int pxv, input int pyv);
        for (int g = 0; g < N; g++) begin
            gx[g] = 11'(x);
            gy[g] = 10'(y);
        end
        px = 11'(pxv);
        py = 10'(pyv);
    endtask

    task automatic rand_pos();
        for (int g = 0; g < N; g++) begin
            gx[g] = 11'($urandom_range(0, 2047));
            gy[g] = 10'($urandom_range(0, 1023));
        end
        px = 11'($urandom_range(0, 2047));
        py = 10'($urandom_range(0, 1023));
    endtask

    // One full scan; fmv < 0 gives random valid-move masks per ghost.
    task automatic run_scan(input int dly, input int fmv, input bit xt);
        int sx[N], sy[N];
        int spx, spy, smode, tx, ty;
        logic [3:0] mv, e;
        for (int g = 0; g < N; g++) begin
            sx[g] = int'(gx[g]);
            sy[g] = int'(gy[g]);
        end
        spx = int'(px);
        spy = int'(py);
        smode = int'(mode);
        if (smode != mq) begin
            for (int g = 0; g < N; g++) revp[g] = 1'b1;
            mq = smode;
        end
        xtick = xt;
        cyc = 0;
        ov = 0;
        tick = 1'b1;
        step();
        rand_pos();
        mode = 2'($urandom_range(0, 3));
        for (int g = 0; g < N; g++) begin
            ack = 1'b0;
            mv = (fmv < 0) ? 4'($urandom_range(0, 15)) : 4'(fmv);
            for (int w = 0; w < dly; w++) begin
                chk("req_wait", o_vm_req, 1);
                chk("pos_x_wait", o_vm_pos_x, sx[g]);
                chk("pos_y_wait", o_vm_pos_y, sy[g]);
                step();
            end
            ack = 1'b1;
            moves = mv;
            chk("req_ack", o_vm_req, 1);
            chk("pos_x", o_vm_pos_x, sx[g]);
            chk("pos_y", o_vm_pos_y, sy[g]);
            step();
            ack = 1'($urandom_range(0, 1));
            moves = 4'($urandom_range(0, 15));
            chk("req_decide", o_vm_req, 0);
            tx = (smode == 0) ? spx : scx[g];
            ty = (smode == 0) ? spy : scy[g];
            e = m_sel(sx[g], sy[g], tx, ty, mv, mdir[g], revp[g]);
            mdir[g] = e;
            revp[g] = 1'b0;
            step();
            chk("dir", o_move_dir[g*4 +: 4], e);
        end
        ack = 1'b0;
        chk("dir_valid", o_dir_valid, 1);
        chk("busy_scan", o_busy, 1);
        chk("latency", cyc, N * (dly + 2) + 1);
        step();
        chk("dv_pulse", o_dir_valid, 0);
        chk("busy_end", o_busy, 0);
        chk("overrun", ov, xt);
        xtick = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            mdir[g] = 4'b1000;
            revp[g] = 1'b0;
        end
        set_pos(100, 100, 300, 150);
        #12;
        chk("rst_dir", o_move_dir, 16'h8888);
        chk("rst_req", o_vm_req, 0);
        chk("rst_dv", o_dir_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovr", o_tick_overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // CHASE toward (300,150): dead-end forces RIGHT, then RIGHT is kept.
        mode = 2'd0; set_pos(100, 100, 300, 150); run_scan(0, 4'b0001, 0);
        chk("all_right_a", o_move_dir, 16'h1111);
        mode = 2'd0; set_pos(100, 100, 300, 150); run_scan(0, 4'b1111, 0);
        chk("chase_right", o_move_dir, 16'h1111);

        // Target straight up; UP excluded as reverse of DOWN.
        mode = 2'd0; set_pos(100, 100, 100, 50); run_scan(0, 4'b0100, 0);
        chk("all_down_a", o_move_dir, 16'h4444);
        mode = 2'd0; set_pos(100, 100, 100, 50); run_scan(0, 4'b1011, 0);
        chk("fallback_right", o_move_dir, 16'h1111);
        mode = 2'd0; set_pos(100, 100, 100, 50); run_scan(0, 4'b0100, 0);
        chk("all_down_b", o_move_dir, 16'h4444);
        mode = 2'd0; set_pos(100, 100, 100, 50); run_scan(0, 4'b0010, 0);
        chk("deadend_up", o_move_dir, 16'h2222);

        // Slow lookup.
        mode = 2'd0; rand_pos(); run_scan(3, -1, 0);

        // Mode switch: everyone reverses once, then follows scatter targets.
        mode = 2'd0; set_pos(500, 500, 0, 0); run_scan(0, 4'b0001, 0);
        chk("all_right_c", o_move_dir, 16'h1111);
        mode = 2'd1; set_pos(500, 500, 0, 0); run_scan(0, 4'b1111, 0);
        chk("mode_reverse", o_move_dir, 16'h8888);
        mode = 2'd1; set_pos(500, 500, 0, 0); run_scan(0, 4'b1111, 0);
        chk("scatter_dirs", o_move_dir, 16'h4822);

        // Tick while busy.
        mode = 2'd0; rand_pos(); run_scan(0, -1, 1);

        for (int i = 0; i < 30; i++) begin
            mode = 2'($urandom_range(0, 2));
            rand_pos();
            run_scan(int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)));
        end

        // Reset while ghost 2 is waiting for its lookup.
        mode = 2'd0; rand_pos();
        xtick = 1'b0; cyc = 0; ov = 0;
        ack = 1'b1; moves = 4'b1111; tick = 1'b1;
        step(); step(); step(); step();
        ack = 1'b0;
        step();
        chk("mid_req", o_vm_req, 1);
        chk("mid_pos", o_vm_pos_x, gx[2]);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req", o_vm_req, 0);
        chk("abort_dir", o_move_dir, 16'h8888);
        chk("abort_busy", o_busy, 0);
        for (int g = 0; g < N; g++) begin
            mdir[g] = 4'b1000;
            revp[g] = 1'b0;
        end
        mq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 2'd0; rand_pos(); run_scan(1, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
